// File: rtl/focus_pkg.sv
// ---------------------------------------------------------------------------
// focus_pkg
// Shared constants for the auto-focus sharpness path:
//   - BT.601-style luma coefficients (77/150/29) and the normalising shift
//   - pipeline latency from frame end to result
//   - default accumulator width and stream field widths
//   - luma_sum(): unshifted 16-bit weighted RGB sum
// ---------------------------------------------------------------------------
package focus_pkg;

    localparam int unsigned LUMA_R_COEF   = 77;
    localparam int unsigned LUMA_G_COEF   = 150;
    localparam int unsigned LUMA_B_COEF   = 29;
    localparam int unsigned LUMA_SHIFT    = 8;

    localparam int unsigned PIPE_LATENCY  = 3;
    localparam int unsigned ACC_W_DEFAULT = 32;

    localparam int unsigned PIX_W         = 8;
    localparam int unsigned COORD_W       = 13;

    // Coefficients sum to 256, so the result never exceeds 255 * 256.
    function automatic logic [15:0] luma_sum(input logic [7:0] r,
                                             input logic [7:0] g,
                                             input logic [7:0] b);
        return 16'(LUMA_R_COEF) * 16'(r)
             + 16'(LUMA_G_COEF) * 16'(g)
             + 16'(LUMA_B_COEF) * 16'(b);
    endfunction

endpackage

// File: rtl/rgb2luma.sv
// ---------------------------------------------------------------------------
// rgb2luma
// One registered stage: Y = (77*R + 150*G + 29*B) >> 8, with a sideband tag
// delayed by the same single cycle so callers can carry flags/coordinates.
//
// Ports:
//   clk       in   pixel clock
//   rst_n     in   asynchronous active-low reset
//   red       in   8-bit red
//   green     in   8-bit green
//   blue      in   8-bit blue
//   tag       in   TAG_W sideband aligned with the pixel
//   luma      out  8-bit registered luma
//   luma_tag  out  TAG_W sideband aligned with luma
// ---------------------------------------------------------------------------
module rgb2luma
    import focus_pkg::*;
#(
    parameter int unsigned TAG_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       red,
    input  logic [7:0]       green,
    input  logic [7:0]       blue,
    input  logic [TAG_W-1:0] tag,
    output logic [7:0]       luma,
    output logic [TAG_W-1:0] luma_tag
);

    logic [15:0] sum;
    logic [7:0]  luma_d;
    logic [7:0]  luma_q;
    logic [TAG_W-1:0] tag_q;

    always_comb begin
        sum    = luma_sum(red, green, blue);
        luma_d = 8'(sum >> LUMA_SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            luma_q <= '0;
            tag_q  <= '0;
        end else begin
            luma_q <= luma_d;
            tag_q  <= tag;
        end
    end

    assign luma     = luma_q;
    assign luma_tag = tag_q;

endmodule

// File: rtl/focus_sharpness_meter.sv
// ---------------------------------------------------------------------------
// focus_sharpness_meter
// Per-frame sharpness figure: sum of thresholded horizontal luma gradients
// between consecutive accepted pixels inside a fixed window.
//
// Optional feature macro: FOCUS_PEAK_HOLD_EN
//   defined   -> oFOCUS_PEAK holds the max reported value since iPEAK_CLR
//   undefined -> oFOCUS_PEAK is constant 0, iPEAK_CLR ignored
//
// Ports:
//   VGA_CLK       in   pixel clock
//   RESET_N       in   asynchronous active-low reset
//   iRed/iGreen/iBlue in 8-bit pixel components
//   iDVAL         in   pixel valid
//   VGA_VS        in   vertical sync, active low
//   H_Cont/V_Cont in   13-bit column/line of current pixel
//   iPEAK_CLR     in   clear peak register (optional feature)
//   oFOCUS_VAL    out  ACC_W last completed frame's focus value
//   oFOCUS_VALID  out  one-cycle pulse when oFOCUS_VAL updates
//   oFOCUS_PEAK   out  ACC_W peak focus value (optional feature)
// ---------------------------------------------------------------------------
module focus_sharpness_meter
    import focus_pkg::*;
#(
    parameter int unsigned WIN_X0   = 160,
    parameter int unsigned WIN_X1   = 480,
    parameter int unsigned WIN_Y0   = 120,
    parameter int unsigned WIN_Y1   = 360,
    parameter int unsigned NOISE_TH = 4,
    parameter int unsigned ACC_W    = ACC_W_DEFAULT
) (
    input  logic               VGA_CLK,
    input  logic               RESET_N,
    input  logic [7:0]         iRed,
    input  logic [7:0]         iGreen,
    input  logic [7:0]         iBlue,
    input  logic               iDVAL,
    input  logic               VGA_VS,
    input  logic [12:0]        H_Cont,
    input  logic [12:0]        V_Cont,
    input  logic               iPEAK_CLR,
    output logic [ACC_W-1:0]   oFOCUS_VAL,
    output logic               oFOCUS_VALID,
    output logic [ACC_W-1:0]   oFOCUS_PEAK
);

    localparam logic [COORD_W-1:0] X0_C    = COORD_W'(WIN_X0);
    localparam logic [COORD_W-1:0] X1_C    = COORD_W'(WIN_X1);
    localparam logic [COORD_W-1:0] Y0_C    = COORD_W'(WIN_Y0);
    localparam logic [COORD_W-1:0] Y1_C    = COORD_W'(WIN_Y1);
    localparam logic [8:0]         NOISE_C = 9'(NOISE_TH);

    // ---------------- acceptance ----------------
    logic accept;

    always_comb begin
        accept = iDVAL & VGA_VS
               & (H_Cont >= X0_C) & (H_Cont < X1_C)
               & (V_Cont >= Y0_C) & (V_Cont < Y1_C);
    end

    // ---------------- stage 1: luma ----------------
    logic [7:0]         s1_y;
    logic [COORD_W:0]   s1_tag;
    logic               s1_acc;
    logic [COORD_W-1:0] s1_h;

    rgb2luma #(
        .TAG_W (COORD_W + 1)
    ) u_rgb2luma (
        .clk      (VGA_CLK),
        .rst_n    (RESET_N),
        .red      (iRed),
        .green    (iGreen),
        .blue     (iBlue),
        .tag      ({accept, H_Cont}),
        .luma     (s1_y),
        .luma_tag (s1_tag)
    );

    assign s1_acc = s1_tag[COORD_W];
    assign s1_h   = s1_tag[COORD_W-1:0];

    // ---------------- stage 2: gradient ----------------
    logic [7:0] yprev_q;
    logic       prev_ok_q;
    logic [7:0] grad_q;
    logic [7:0] diff;
    logic       pair_ok;
    logic [7:0] grad_d;

    always_comb begin
        diff    = (s1_y >= yprev_q) ? (s1_y - yprev_q) : (yprev_q - s1_y);
        // The window's first column always starts a new pair chain, even if
        // the upstream stream had no DVAL gap at the line boundary.
        pair_ok = s1_acc & prev_ok_q & (s1_h != X0_C);
        grad_d  = (pair_ok && ({1'b0, diff} >= NOISE_C)) ? diff : 8'd0;
    end

    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            yprev_q   <= '0;
            prev_ok_q <= 1'b0;
            grad_q    <= '0;
        end else begin
            prev_ok_q <= s1_acc;
            grad_q    <= grad_d;
            if (s1_acc) begin
                yprev_q <= s1_y;
            end
        end
    end

    // ---------------- stage 3: accumulate, frame end ----------------
    logic [ACC_W-1:0]        acc_q;
    logic [ACC_W:0]          acc_sum;
    logic [ACC_W-1:0]        acc_sat;
    logic                    vs_q;
    logic [PIPE_LATENCY-1:0] end_sr_q;
    logic                    vs_fall;
    logic                    frame_done;
    logic                    first_frame_q;
    logic [ACC_W-1:0]        focus_val_q;
    logic                    focus_valid_q;

    always_comb begin
        acc_sum    = {1'b0, acc_q} + (ACC_W + 1)'(grad_q);
        acc_sat    = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
        vs_fall    = vs_q & ~VGA_VS;
        frame_done = end_sr_q[PIPE_LATENCY-1];
    end

    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            acc_q         <= '0;
            vs_q          <= 1'b0;
            end_sr_q      <= '0;
            first_frame_q <= 1'b1;
            focus_val_q   <= '0;
            focus_valid_q <= 1'b0;
        end else begin
            vs_q          <= VGA_VS;
            end_sr_q      <= {end_sr_q[PIPE_LATENCY-2:0], vs_fall};
            focus_valid_q <= 1'b0;
            if (frame_done) begin
                // Pipeline is drained here: no pixel is accepted while VS is low.
                if (!first_frame_q) begin
                    focus_val_q   <= acc_q;
                    focus_valid_q <= 1'b1;
                end
                acc_q         <= '0;
                first_frame_q <= 1'b0;
            end else begin
                acc_q <= acc_sat;
            end
        end
    end

    assign oFOCUS_VAL   = focus_val_q;
    assign oFOCUS_VALID = focus_valid_q;

    // ---------------- optional peak hold ----------------
`ifdef FOCUS_PEAK_HOLD_EN
    logic [ACC_W-1:0] peak_q;

    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            peak_q <= '0;
        end else if (iPEAK_CLR) begin
            peak_q <= '0;
        end else if (frame_done && !first_frame_q && (acc_q > peak_q)) begin
            // Loads on the same edge as oFOCUS_VAL.
            peak_q <= acc_q;
        end
    end

    assign oFOCUS_PEAK = peak_q;
`else
    logic unused_peak_clr;
    assign unused_peak_clr = iPEAK_CLR;
    assign oFOCUS_PEAK     = '0;
`endif

endmodule

// File: tb/tb_focus_sharpness_meter.sv
module tb_focus_sharpness_meter;

    localparam int X0    = 4;
    localparam int X1    = 36;
    localparam int Y0    = 2;
    localparam int Y1    = 12;
    localparam int COLS  = 40;
    localparam int LINES = 14;
    localparam int NOISE = 4;
    localparam longint SAT16 = 65535;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  red, green, blue;
    logic        dval, vs, peak_clr;
    logic [12:0] hc, vc;
    logic [31:0] val, peak;
    logic        valid;
    logic [15:0] val_s, peak_s;
    logic        valid_s;

    int checks = 0;
    int errors = 0;

    int fr [LINES][COLS];
    int fg [LINES][COLS];
    int fb [LINES][COLS];
    bit fdv[LINES][COLS];

    longint model_val, model_val_s, model_peak;

    always #20 clk = ~clk;

    focus_sharpness_meter #(
        .WIN_X0(X0), .WIN_X1(X1), .WIN_Y0(Y0), .WIN_Y1(Y1), .NOISE_TH(NOISE), .ACC_W(32)
    ) dut (
        .VGA_CLK(clk), .RESET_N(rst_n), .iRed(red), .iGreen(green), .iBlue(blue),
        .iDVAL(dval), .VGA_VS(vs), .H_Cont(hc), .V_Cont(vc), .iPEAK_CLR(peak_clr),
        .oFOCUS_VAL(val), .oFOCUS_VALID(valid), .oFOCUS_PEAK(peak)
    );

    focus_sharpness_meter #(
        .WIN_X0(X0), .WIN_X1(X1), .WIN_Y0(Y0), .WIN_Y1(Y1), .NOISE_TH(NOISE), .ACC_W(16)
    ) dut_sat (
        .VGA_CLK(clk), .RESET_N(rst_n), .iRed(red), .iGreen(green), .iBlue(blue),
        .iDVAL(dval), .VGA_VS(vs), .H_Cont(hc), .V_Cont(vc), .iPEAK_CLR(peak_clr),
        .oFOCUS_VAL(val_s), .oFOCUS_VALID(valid_s), .oFOCUS_PEAK(peak_s)
    );

    function automatic int luma(input int r, input int g, input int b);
        return (77 * r + 150 * g + 29 * b) / 256;
    endfunction

    // Sum of thresholded |dY| over horizontally adjacent valid window pixels.
    function automatic longint model_frame();
        longint sum;
        int d;
        sum = 0;
        for (int y = Y0; y < Y1; y++) begin
            for (int x = X0 + 1; x < X1; x++) begin
                if (fdv[y][x] && fdv[y][x-1]) begin
                    d = luma(fr[y][x], fg[y][x], fb[y][x])
                      - luma(fr[y][x-1], fg[y][x-1], fb[y][x-1]);
                    if (d < 0) d = -d;
                    if (d >= NOISE) sum += d;
                end
            end
        end
        return sum;
    endfunction

    function automatic longint sat16(input longint v);
        return (v > SAT16) ? SAT16 : v;
    endfunction

    // mode 0 grey, 1 stripes, 2 ramp(step), 3 random
    task automatic build_frame(input int mode, input int step);
        int v;
        v = 0;
        for (int y = 0; y < LINES; y++) begin
            for (int x = 0; x < COLS; x++) begin
                fdv[y][x] = 1'b1;
                case (mode)
                    0: v = 100;
                    1: v = (x % 2 == 1) ? 255 : 0;
                    2: v = (x * step) % 256;
                    default: begin
                        if (x == 0) v = $urandom_range(0, 255);
                        else v = v + $urandom_range(0, 12) - 6;
                        if (v < 0) v = 0;
                        if (v > 255) v = 255;
                        fdv[y][x] = ($urandom_range(0, 9) != 0);
                    end
                endcase
                fr[y][x] = v;
                fg[y][x] = v;
                fb[y][x] = v;
                if (mode == 3 && $urandom_range(0, 7) == 0) begin
                    fr[y][x] = $urandom_range(0, 255);
                    fg[y][x] = $urandom_range(0, 255);
                    fb[y][x] = $urandom_range(0, 255);
                end
            end
        end
    endtask

    task automatic drive_lines(input int ya, input int yb);
        for (int y = ya; y < yb; y++) begin
            for (int x = 0; x < COLS; x++) begin
                @(negedge clk);
                hc    = 13'(x);
                vc    = 13'(y);
                red   = 8'(fr[y][x]);
                green = 8'(fg[y][x]);
                blue  = 8'(fb[y][x]);
                dval  = fdv[y][x];
            end
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                dval = 1'b0;
                hc   = 13'(COLS);
                red  = 8'($urandom_range(0, 255));
            end
        end
    endtask

    // Drops VS and watches for the result pulse; in-window DVAL pixels are
    // driven while VS is low and must not be accumulated.
    task automatic end_frame(input bit expect_pulse, input longint exp_val, input string name);
        int pulses, pulses_s, at;
        logic [31:0] got, got_pk;
        logic [15:0] got_s;
        longint exp_pk;
        pulses = 0; pulses_s = 0; at = -1;
        got = val; got_s = val_s; got_pk = peak;
        @(negedge clk);
        vs = 1'b0; dval = 1'b1; hc = 13'(X0 + 2); vc = 13'(Y0 + 2);
        red = 8'($urandom_range(0, 255)); green = 8'($urandom_range(0, 255));
        blue = 8'($urandom_range(0, 255));
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                pulses++; at = i; got = val; got_pk = peak;
            end
            if (valid_s === 1'b1) begin
                pulses_s++; got_s = val_s;
            end
            red = 8'($urandom_range(0, 255)); green = 8'($urandom_range(0, 255));
            blue = 8'($urandom_range(0, 255));
            if (i == 8) begin
                vs = 1'b1; dval = 1'b0;
            end
        end
        if (expect_pulse) begin
            model_val   = exp_val;
            model_val_s = sat16(exp_val);
            if (exp_val > model_peak) model_peak = exp_val;
        end
`ifdef FOCUS_PEAK_HOLD_EN
        exp_pk = model_peak;
`else
        exp_pk = 0;
`endif
        checks++;
        if (pulses !== (expect_pulse ? 1 : 0) || (expect_pulse && at !== 4)) begin
            errors++;
            $display("FAIL %s pulse: got %0d pulses at cycle %0d, need %0d at cycle 4",
                     name, pulses, at, expect_pulse ? 1 : 0);
        end
        checks++;
        if (longint'(got) !== model_val) begin
            errors++;
            $display("FAIL %s value: got %0d, need %0d", name, got, model_val);
        end
        checks++;
        if (pulses_s !== pulses || longint'(got_s) !== model_val_s) begin
            errors++;
            $display("FAIL %s sat16: got %0d (pulses %0d), need %0d (pulses %0d)",
                     name, got_s, pulses_s, model_val_s, pulses);
        end
        checks++;
        if (longint'(got_pk) !== exp_pk) begin
            errors++;
            $display("FAIL %s peak: got %0d, need %0d", name, got_pk, exp_pk);
        end
        checks++;
        if (longint'(val) !== model_val || valid !== 1'b0) begin
            errors++;
            $display("FAIL %s hold: got %0d valid %b, need %0d valid 0",
                     name, val, valid, model_val);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (val !== 32'd0 || valid !== 1'b0 || peak !== 32'd0 || val_s !== 16'd0 ||
            valid_s !== 1'b0 || peak_s !== 16'd0) begin
            errors++;
            $display("FAIL %s: got val %0d valid %b peak %0d sval %0d svalid %b, need all 0",
                     name, val, valid, peak, val_s, valid_s);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vs = 1'b1; dval = 1'b0; peak_clr = 1'b0;
        hc = '0; vc = '0; red = '0; green = '0; blue = '0;
        model_val = 0; model_val_s = 0; model_peak = 0;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_grey();
        build_frame(0, 0);
        drive_lines(0, LINES);
        end_frame(1'b0, 0, "grey_first_frame");
        drive_lines(0, LINES);
        end_frame(1'b1, model_frame(), "grey_second_frame");
    endtask

    task automatic test_stripes();
        build_frame(1, 0);
        drive_lines(0, LINES);
        end_frame(1'b1, 31 * 10 * 255, "stripes");
    endtask

    task automatic test_ramp();
        build_frame(2, 3);
        drive_lines(0, LINES);
        end_frame(1'b1, 0, "ramp_step3");
        build_frame(2, 4);
        drive_lines(0, LINES);
        end_frame(1'b1, 31 * 10 * 4, "ramp_step4");
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            build_frame(3, 0);
            drive_lines(0, LINES);
            end_frame(1'b1, model_frame(), "random_frame");
        end
    endtask

    task automatic test_reset_mid_frame();
        build_frame(3, 0);
        drive_lines(0, LINES / 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_val = 0; model_val_s = 0; model_peak = 0;
        check_zero("reset_mid_frame");
        @(negedge clk);
        rst_n = 1'b1;
        drive_lines(LINES / 2, LINES);
        end_frame(1'b0, 0, "after_reset_partial");
        build_frame(3, 0);
        drive_lines(0, LINES);
        end_frame(1'b1, model_frame(), "after_reset_full");
    endtask

    task automatic test_peak();
        for (int n = 0; n < 3; n++) begin
            build_frame(3, 0);
            drive_lines(0, LINES);
            end_frame(1'b1, model_frame(), "peak_frame");
        end
        @(negedge clk);
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        model_peak = 0;
        checks++;
        if (peak !== 32'd0) begin
            errors++;
            $display("FAIL peak_clear: got %0d, need 0", peak);
        end
        build_frame(2, 4);
        drive_lines(0, LINES);
        end_frame(1'b1, 31 * 10 * 4, "peak_after_clear");
    endtask

    task automatic test_back_to_back();
        build_frame(1, 0);
        drive_lines(0, LINES);
        end_frame(1'b1, 31 * 10 * 255, "b2b_stripes");
        build_frame(0, 0);
        drive_lines(0, LINES);
        end_frame(1'b1, 0, "b2b_grey");
    endtask

    initial begin
        test_reset();
        test_grey();
        test_stripes();
        test_ramp();
        test_random();
        test_reset_mid_frame();
        test_peak();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
